// File: rtl/rob_commit_buffer.sv
// rob_commit_buffer: in-order reorder buffer with two out-of-order writeback ports and in-order single commit
module rob_commit_buffer #(
  parameter int ROB_ENTRY = 8,
  parameter int WORD_SIZE_P = 16,
  parameter int NUM_PHYS_REG = 32,
  parameter int NUM_FLAGS = 4,
  localparam int AW = $clog2(ROB_ENTRY),
  localparam int RW = $clog2(NUM_PHYS_REG)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   alloc_v_i,
  input  logic                   alloc_w_v_i,
  output logic                   alloc_ready_o,
  output logic [AW-1:0]          alloc_idx_o,
  input  logic                   wb0_v_i,
  input  logic [AW-1:0]          wb0_rob_dest_i,
  input  logic [RW-1:0]          wb0_reg_dest_i,
  input  logic [NUM_FLAGS-1:0]   wb0_flags_i,
  input  logic [WORD_SIZE_P-1:0] wb0_result_i,
  input  logic                   wb1_v_i,
  input  logic [AW-1:0]          wb1_rob_dest_i,
  input  logic [RW-1:0]          wb1_reg_dest_i,
  input  logic [NUM_FLAGS-1:0]   wb1_flags_i,
  input  logic [WORD_SIZE_P-1:0] wb1_result_i,
  output logic                   commit_v_o,
  input  logic                   commit_ready_i,
  output logic                   commit_w_v_o,
  output logic [RW-1:0]          commit_reg_dest_o,
  output logic [NUM_FLAGS-1:0]   commit_flags_o,
  output logic [WORD_SIZE_P-1:0] commit_result_o,
  output logic [AW:0]            count_o,
  output logic                   wb_err_o
);
  logic [ROB_ENTRY-1:0] busy, done, w_v;
  logic [RW-1:0] reg_dest [ROB_ENTRY];
  logic [NUM_FLAGS-1:0] flags [ROB_ENTRY];
  logic [WORD_SIZE_P-1:0] result [ROB_ENTRY];
  logic [AW-1:0] head, tail;
  logic alloc_fire, commit_fire, wb_same, wb0_ok, wb1_ok, wb_bad;
  always_comb begin
    alloc_ready_o = count_o != (AW+1)'(ROB_ENTRY);
    alloc_idx_o = tail;
    commit_v_o = busy[head] & done[head];
    commit_w_v_o = commit_v_o & w_v[head];
    commit_reg_dest_o = commit_v_o ? reg_dest[head] : '0;
    commit_flags_o = commit_v_o ? flags[head] : '0;
    commit_result_o = commit_v_o ? result[head] : '0;
    alloc_fire = alloc_v_i & alloc_ready_o;
    commit_fire = commit_v_o & commit_ready_i;
    wb_same = wb0_v_i & wb1_v_i & (wb0_rob_dest_i == wb1_rob_dest_i);
    wb0_ok = wb0_v_i & busy[wb0_rob_dest_i] & ~done[wb0_rob_dest_i];
    wb1_ok = wb1_v_i & ~wb_same & busy[wb1_rob_dest_i] & ~done[wb1_rob_dest_i];
    wb_bad = (wb0_v_i & ~wb0_ok) | (wb1_v_i & ~wb1_ok);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      busy <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count_o <= '0;
      wb_err_o <= wb_err_o & ~reset_i;
    end else begin
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        w_v[tail] <= alloc_w_v_i;
        tail <= tail + AW'(1);
      end
      if (commit_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head <= head + AW'(1);
      end
      if (wb0_ok) begin
        done[wb0_rob_dest_i] <= 1'b1;
        reg_dest[wb0_rob_dest_i] <= wb0_reg_dest_i;
        flags[wb0_rob_dest_i] <= wb0_flags_i;
        result[wb0_rob_dest_i] <= wb0_result_i;
      end
      if (wb1_ok) begin
        done[wb1_rob_dest_i] <= 1'b1;
        reg_dest[wb1_rob_dest_i] <= wb1_reg_dest_i;
        flags[wb1_rob_dest_i] <= wb1_flags_i;
        result[wb1_rob_dest_i] <= wb1_result_i;
      end
      count_o <= count_o + (AW+1)'(alloc_fire) - (AW+1)'(commit_fire);
      wb_err_o <= wb_err_o | wb_bad;
    end
  end
endmodule

// File: tb/tb_rob_commit_buffer.sv
// tb_rob_commit_buffer: directed and randomized checks of rob_commit_buffer against a behavioural model
module tb_rob_commit_buffer;
  localparam int N = 8;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset_i = 1, flush_i = 0, alloc_v_i = 0, alloc_w_v_i = 0, commit_ready_i = 0;
  logic wb0_v_i = 0, wb1_v_i = 0;
  logic [2:0] wb0_rob_dest_i = 0, wb1_rob_dest_i = 0;
  logic [4:0] wb0_reg_dest_i = 0, wb1_reg_dest_i = 0;
  logic [3:0] wb0_flags_i = 0, wb1_flags_i = 0;
  logic [15:0] wb0_result_i = 0, wb1_result_i = 0;
  logic alloc_ready_o, commit_v_o, commit_w_v_o, wb_err_o;
  logic [2:0] alloc_idx_o;
  logic [4:0] commit_reg_dest_o;
  logic [3:0] commit_flags_o;
  logic [15:0] commit_result_o;
  logic [3:0] count_o;
  rob_commit_buffer dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .alloc_v_i(alloc_v_i), .alloc_w_v_i(alloc_w_v_i),
    .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wb0_v_i(wb0_v_i), .wb0_rob_dest_i(wb0_rob_dest_i), .wb0_reg_dest_i(wb0_reg_dest_i),
    .wb0_flags_i(wb0_flags_i), .wb0_result_i(wb0_result_i),
    .wb1_v_i(wb1_v_i), .wb1_rob_dest_i(wb1_rob_dest_i), .wb1_reg_dest_i(wb1_reg_dest_i),
    .wb1_flags_i(wb1_flags_i), .wb1_result_i(wb1_result_i),
    .commit_v_o(commit_v_o), .commit_ready_i(commit_ready_i), .commit_w_v_o(commit_w_v_o),
    .commit_reg_dest_o(commit_reg_dest_o), .commit_flags_o(commit_flags_o),
    .commit_result_o(commit_result_o), .count_o(count_o), .wb_err_o(wb_err_o)
  );
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  bit m_busy [N];
  bit m_done [N];
  bit m_wv [N];
  int m_rd [N];
  int m_fl [N];
  int m_res [N];
  int m_head, m_tail;
  bit m_err;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction
  function automatic bit m_cv();
    return m_busy[m_head] && m_done[m_head];
  endfunction
  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
    end
    m_head = 0;
    m_tail = 0;
  endtask
  task automatic model_step();
    bit cv, ar, same, ok0, ok1;
    int d0, d1;
    cv = m_cv();
    ar = m_count() != N;
    d0 = int'(wb0_rob_dest_i);
    d1 = int'(wb1_rob_dest_i);
    if (reset_i) begin
      m_clear();
      m_err = 0;
    end else if (flush_i) m_clear();
    else begin
      same = wb0_v_i && wb1_v_i && d0 == d1;
      ok0 = wb0_v_i && m_busy[d0] && !m_done[d0];
      ok1 = wb1_v_i && !same && m_busy[d1] && !m_done[d1];
      if ((wb0_v_i && !ok0) || (wb1_v_i && !ok1)) m_err = 1;
      if (cv && commit_ready_i) begin
        m_busy[m_head] = 0;
        m_done[m_head] = 0;
        m_head = (m_head + 1) % N;
      end
      if (alloc_v_i && ar) begin
        m_busy[m_tail] = 1;
        m_done[m_tail] = 0;
        m_wv[m_tail] = alloc_w_v_i;
        m_tail = (m_tail + 1) % N;
      end
      if (ok0) begin
        m_done[d0] = 1;
        m_rd[d0] = int'(wb0_reg_dest_i);
        m_fl[d0] = int'(wb0_flags_i);
        m_res[d0] = int'(wb0_result_i);
      end
      if (ok1) begin
        m_done[d1] = 1;
        m_rd[d1] = int'(wb1_reg_dest_i);
        m_fl[d1] = int'(wb1_flags_i);
        m_res[d1] = int'(wb1_result_i);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    reset_i = 0;
    flush_i = 0;
    alloc_v_i = 0;
    alloc_w_v_i = 0;
    wb0_v_i = 0;
    wb1_v_i = 0;
    commit_ready_i = 0;
  endtask
  task automatic wb(int port, int dest, int res);
    if (port == 0) begin
      wb0_v_i = 1;
      wb0_rob_dest_i = 3'(dest);
      wb0_reg_dest_i = 5'(dest + 7);
      wb0_flags_i = 4'(res);
      wb0_result_i = 16'(res);
    end else begin
      wb1_v_i = 1;
      wb1_rob_dest_i = 3'(dest);
      wb1_reg_dest_i = 5'(dest + 11);
      wb1_flags_i = 4'(res >> 4);
      wb1_result_i = 16'(res);
    end
  endtask
  function automatic int pick();
    int c[$];
    for (int i = 0; i < N; i++) if (m_busy[i] && !m_done[i]) c.push_back(i);
    if (c.size() > 0 && $urandom_range(0, 9) < 8) return c[$urandom_range(0, c.size() - 1)];
    return int'($urandom_range(0, N - 1));
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("alloc_ready", int'(alloc_ready_o), int'(m_count() != N));
    chk("alloc_idx", int'(alloc_idx_o), m_tail);
    chk("count", int'(count_o), m_count());
    chk("commit_v", int'(commit_v_o), int'(m_cv()));
    chk("commit_w_v", int'(commit_w_v_o), m_cv() ? int'(m_wv[m_head]) : 0);
    chk("commit_reg_dest", int'(commit_reg_dest_o), m_cv() ? m_rd[m_head] : 0);
    chk("commit_flags", int'(commit_flags_o), m_cv() ? m_fl[m_head] : 0);
    chk("commit_result", int'(commit_result_o), m_cv() ? m_res[m_head] : 0);
    chk("wb_err", int'(wb_err_o), int'(m_err));
  end
  initial begin
    step();
    chk_en = 1;
    chk("rst_ready", int'(alloc_ready_o), 1);
    chk("rst_idx", int'(alloc_idx_o), 0);
    chk("rst_commit_v", int'(commit_v_o), 0);
    chk("rst_result", int'(commit_result_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_err", int'(wb_err_o), 0);
    for (int i = 0; i < 3; i++) begin
      chk("seq_idx", int'(alloc_idx_o), i);
      alloc_v_i = 1;
      alloc_w_v_i = 1;
      step();
    end
    chk("three_count", int'(count_o), 3);
    chk("three_commit_v", int'(commit_v_o), 0);
    wb(0, 2, 3);
    step();
    chk("wb2_commit_v", int'(commit_v_o), 0);
    wb(0, 0, 1);
    step();
    chk("wb0_commit_v", int'(commit_v_o), 1);
    chk("commit_a", int'(commit_result_o), 1);
    commit_ready_i = 1;
    wb(0, 1, 2);
    step();
    chk("commit_b", int'(commit_result_o), 2);
    commit_ready_i = 1;
    step();
    chk("commit_c", int'(commit_result_o), 3);
    commit_ready_i = 1;
    step();
    chk("drained_v", int'(commit_v_o), 0);
    chk("drained_count", int'(count_o), 0);
    reset_i = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      alloc_v_i = 1;
      alloc_w_v_i = 1;
      step();
    end
    chk("full_ready", int'(alloc_ready_o), 0);
    chk("full_count", int'(count_o), 8);
    alloc_v_i = 1;
    step();
    chk("drop_count", int'(count_o), 8);
    wb(0, 0, 'h11);
    step();
    commit_ready_i = 1;
    alloc_v_i = 1;
    step();
    chk("refuse_count", int'(count_o), 7);
    chk("refuse_idx", int'(alloc_idx_o), 0);
    chk("refuse_ready", int'(alloc_ready_o), 1);
    alloc_v_i = 1;
    step();
    chk("wrap_count", int'(count_o), 8);
    chk("wrap_idx", int'(alloc_idx_o), 1);
    wb(0, 4, 'hAAAA);
    wb(1, 4, 'hBBBB);
    step();
    chk("dual_err", int'(wb_err_o), 1);
    wb(0, 1, 'h101);
    wb(1, 2, 'h102);
    step();
    wb(0, 3, 'h103);
    step();
    for (int i = 1; i < 4; i++) begin
      chk("drain_res", int'(commit_result_o), 'h100 + i);
      commit_ready_i = 1;
      step();
    end
    chk("port0_wins", int'(commit_result_o), 'hAAAA);
    step();
    step();
    chk("hold_v", int'(commit_v_o), 1);
    chk("hold_res", int'(commit_result_o), 'hAAAA);
    chk("hold_count", int'(count_o), 5);
    commit_ready_i = 1;
    step();
    chk("one_commit_v", int'(commit_v_o), 0);
    chk("one_commit_count", int'(count_o), 4);
    reset_i = 1;
    step();
    chk("reset_err", int'(wb_err_o), 0);
    wb(0, 5, 1);
    step();
    chk("free_err", int'(wb_err_o), 1);
    for (int i = 0; i < 5; i++) begin
      alloc_v_i = 1;
      step();
    end
    wb(0, 0, 'h20);
    wb(1, 1, 'h21);
    step();
    flush_i = 1;
    alloc_v_i = 1;
    step();
    chk("flush_count", int'(count_o), 0);
    chk("flush_idx", int'(alloc_idx_o), 0);
    chk("flush_commit_v", int'(commit_v_o), 0);
    chk("flush_err", int'(wb_err_o), 1);
    for (int c = 0; c < 4000; c++) begin
      reset_i = $urandom_range(0, 199) == 0;
      flush_i = $urandom_range(0, 49) == 0;
      alloc_v_i = $urandom_range(0, 9) < 6;
      alloc_w_v_i = 1'($urandom);
      commit_ready_i = $urandom_range(0, 9) < 7;
      wb0_v_i = 1'($urandom);
      wb0_rob_dest_i = 3'(pick());
      wb0_reg_dest_i = 5'($urandom);
      wb0_flags_i = 4'($urandom);
      wb0_result_i = 16'($urandom);
      wb1_v_i = 1'($urandom);
      wb1_rob_dest_i = 3'(pick());
      wb1_reg_dest_i = 5'($urandom);
      wb1_flags_i = 4'($urandom);
      wb1_result_i = 16'($urandom);
      step();
    end
    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
